// File: rtl/lane_packer.sv
// Serial-to-parallel lane packer: collects NUM_LANES bits LSB-first and queues words in a 2-entry FIFO.
// Optional per-entry parity output is enabled by defining LANE_PACKER_PARITY_EN.
module lane_packer #(
    parameter int NUM_LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_bit,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NUM_LANES-1:0] o_data_out,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [7:0]           o_word_count
`ifdef LANE_PACKER_PARITY_EN
    ,
    output logic                 o_parity
`endif
);

    localparam int CNT_W = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_LANES - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_LANES-2:0] acc_q, acc_d;
    logic [NUM_LANES-1:0] mem_q [2];
    logic [NUM_LANES-1:0] mem_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           occ_q, occ_d;
    logic [7:0]           word_count_q, word_count_d;
`ifdef LANE_PACKER_PARITY_EN
    logic [1:0]           par_q, par_d;
`endif

    logic cnt_last;
    logic fifo_full;
    logic ready;
    logic in_xfer;
    logic push;
    logic pop;
    logic [NUM_LANES-1:0] new_word;

    // Acceptance depends only on state so there is no path from i_ready to o_ready.
    always_comb begin
        cnt_last  = (cnt_q == CNT_LAST);
        fifo_full = (occ_q == 2'd2);
        ready     = !(cnt_last && fifo_full);
        in_xfer   = i_valid && ready;
        push      = in_xfer && cnt_last;
        pop       = (occ_q != 2'd0) && i_ready;
        new_word  = {i_bit, acc_q};
    end

    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        word_count_d = word_count_q;
`ifdef LANE_PACKER_PARITY_EN
        par_d        = par_q;
`endif

        if (in_xfer) begin
            if (cnt_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int k = 0; k < NUM_LANES - 1; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        acc_d[k] = i_bit;
                    end
                end
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = new_word;
            wr_ptr_d        = ~wr_ptr_q;
`ifdef LANE_PACKER_PARITY_EN
            par_d[wr_ptr_q] = ^new_word;
`endif
        end

        if (pop) begin
            rd_ptr_d     = ~rd_ptr_q;
            word_count_d = word_count_q + 8'd1;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
            word_count_q <= 8'd0;
`ifdef LANE_PACKER_PARITY_EN
            par_q        <= 2'b00;
`endif
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            word_count_q <= word_count_d;
`ifdef LANE_PACKER_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign o_ready      = ready;
    assign o_valid      = (occ_q != 2'd0);
    assign o_data_out   = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_word_count = word_count_q;
`ifdef LANE_PACKER_PARITY_EN
    assign o_parity     = o_valid ? par_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_lane_packer.sv
// Self-checking bench for lane_packer (NUM_LANES = 2) against a queue-based reference model.
module tb_lane_packer;
    localparam int N = 2;

    logic         clk;
    logic         rst;
    logic         i_bit;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] o_data_out;
    logic         o_valid;
    logic         i_ready;
    logic [7:0]   o_word_count;
`ifdef LANE_PACKER_PARITY_EN
    logic         o_parity;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: accepted bits of the partial word, queue of completed words, pop count.
    int         part_val;
    int         part_n;
    int         mq[$];
    logic [7:0] wc_m;

    lane_packer #(.NUM_LANES(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_bit        (i_bit),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_data_out   (o_data_out),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_word_count (o_word_count)
`ifdef LANE_PACKER_PARITY_EN
        ,
        .o_parity     (o_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic m_ready();
        return !(part_n == N - 1 && mq.size() == 2);
    endfunction

    function automatic logic m_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [N-1:0] m_data();
        return (mq.size() != 0) ? N'(mq[0]) : '0;
    endfunction

    function automatic logic m_parity();
        return (mq.size() != 0) ? logic'($countones(mq[0]) % 2) : 1'b0;
    endfunction

    // Drives one cycle of inputs, advances the model across the clock edge, returns at the next negedge.
    task automatic step(input logic r, input logic v, input logic b, input logic rd);
        logic rdy_m, take, pop_m;
        rst = r; i_valid = v; i_bit = b; i_ready = rd;
        rdy_m = m_ready();
        take  = v && rdy_m;
        pop_m = m_valid() && rd;
        @(posedge clk);
        if (r) begin
            part_val = 0; part_n = 0; mq.delete(); wc_m = 8'd0;
        end else begin
            if (pop_m) begin
                void'(mq.pop_front());
                wc_m = wc_m + 8'd1;
            end
            if (take) begin
                part_val = part_val + (int'(b) << part_n);
                part_n   = part_n + 1;
                if (part_n == N) begin
                    mq.push_back(part_val);
                    part_val = 0;
                    part_n   = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_data_out !== 2'b00) begin n_err++; $display("FAIL reset_data: got %b want 00", o_data_out); end
        n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_cmp++; if (o_word_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", o_word_count); end
        step(0, 0, 0, 1);
        n_cmp++; if (o_valid !== 1'b0 || o_word_count !== 8'd0) begin
            n_err++; $display("FAIL reset_noword: valid %b count %0d want 0 0", o_valid, o_word_count);
        end
    endtask

    task automatic test_order_latency();
        step(0, 1, 1, 1);
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL order_early_valid: got %b want 0", o_valid); end
        step(0, 1, 0, 1);
        n_cmp++; if (o_valid !== 1'b1 || o_data_out !== 2'b01) begin
            n_err++; $display("FAIL order_word: valid %b data %b want 1 01", o_valid, o_data_out);
        end
        step(0, 0, 0, 1);
        n_cmp++; if (o_word_count !== 8'd1 || o_word_count !== wc_m) begin
            n_err++; $display("FAIL order_count: got %0d want 1", o_word_count);
        end
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL order_drained: got %b want 0", o_valid); end
    endtask

    task automatic test_backpressure();
        logic [4:0] bits;
        bits = 5'b11011; // streamed LSB first: 1,1,0,1,1
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept_%0d: ready %b want 1", i, o_ready); end
            step(0, 1, bits[i], 0);
        end
        n_cmp++; if (o_valid !== 1'b1 || o_data_out !== 2'b11) begin
            n_err++; $display("FAIL bp_head: valid %b data %b want 1 11", o_valid, o_data_out);
        end
        n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", o_ready); end
        step(0, 1, 0, 0);
        n_cmp++; if (o_ready !== 1'b0 || o_data_out !== 2'b11 || o_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_hold: ready %b valid %b data %b want 0 1 11", o_ready, o_valid, o_data_out);
        end
        step(0, 0, 0, 1);
        n_cmp++; if (o_data_out !== 2'b10 || o_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_second: data %b ready %b want 10 1", o_data_out, o_ready);
        end
        step(0, 0, 0, 1);
        n_cmp++; if (o_valid !== 1'b0 || o_word_count !== wc_m) begin
            n_err++; $display("FAIL bp_drain: valid %b count %0d want 0 %0d", o_valid, o_word_count, wc_m);
        end
    endtask

    task automatic test_simul_push_pop();
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        n_cmp++; if (o_valid !== 1'b1 || o_data_out !== 2'b01) begin
            n_err++; $display("FAIL simul_pre: valid %b data %b want 1 01", o_valid, o_data_out);
        end
        step(0, 1, 1, 1);
        n_cmp++; if (o_valid !== 1'b1 || o_data_out !== 2'b11 || o_word_count !== 8'd1) begin
            n_err++; $display("FAIL simul_both: valid %b data %b count %0d want 1 11 1", o_valid, o_data_out, o_word_count);
        end
        step(0, 0, 0, 1);
        n_cmp++; if (o_valid !== 1'b0 || o_word_count !== 8'd2) begin
            n_err++; $display("FAIL simul_drain: valid %b count %0d want 0 2", o_valid, o_word_count);
        end
    endtask

    task automatic test_midword_reset();
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        n_cmp++; if (o_valid !== 1'b1 || o_data_out !== 2'b10 || o_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_word: valid %b data %b ready %b want 1 10 1", o_valid, o_data_out, o_ready);
        end
        step(0, 0, 0, 1);
        n_cmp++; if (o_valid !== 1'b0 || o_word_count !== 8'd1) begin
            n_err++; $display("FAIL midrst_only: valid %b count %0d want 0 1", o_valid, o_word_count);
        end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 64) == 0, ($urandom % 4) != 0, 1'($urandom), ($urandom % 3) != 0);
            n_cmp++;
            if (o_valid !== m_valid() || o_data_out !== m_data() || o_ready !== m_ready() || o_word_count !== wc_m) begin
                n_err++;
                $display("FAIL rand_%0d: valid %b data %b ready %b count %0d want %b %b %b %0d",
                         i, o_valid, o_data_out, o_ready, o_word_count, m_valid(), m_data(), m_ready(), wc_m);
            end
`ifdef LANE_PACKER_PARITY_EN
            n_cmp++; if (o_parity !== m_parity()) begin
                n_err++; $display("FAIL rand_parity_%0d: got %b want %b", i, o_parity, m_parity());
            end
`endif
        end
    endtask

    task automatic test_wrap_parity();
        bit saw_255;
        saw_255 = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 512; i++) begin
            step(0, 1, 1'($urandom), 1);
            if (o_word_count == 8'd255) saw_255 = 1;
            n_cmp++;
            if (o_valid !== m_valid() || o_data_out !== m_data() || o_word_count !== wc_m) begin
                n_err++;
                $display("FAIL wrap_%0d: valid %b data %b count %0d want %b %b %0d",
                         i, o_valid, o_data_out, o_word_count, m_valid(), m_data(), wc_m);
            end
        end
        step(0, 0, 0, 1);
        n_cmp++; if (o_word_count !== 8'd0 || !saw_255) begin
            n_err++; $display("FAIL wrap_zero: count %0d saw255 %0d want 0 1", o_word_count, saw_255);
        end
`ifdef LANE_PACKER_PARITY_EN
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        n_cmp++; if (o_data_out !== 2'b01 || o_parity !== 1'b1) begin
            n_err++; $display("FAIL parity_01: data %b parity %b want 01 1", o_data_out, o_parity);
        end
        step(0, 0, 0, 1);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        n_cmp++; if (o_data_out !== 2'b11 || o_parity !== 1'b0) begin
            n_err++; $display("FAIL parity_11: data %b parity %b want 11 0", o_data_out, o_parity);
        end
        step(0, 0, 0, 1);
        n_cmp++; if (o_parity !== 1'b0 || o_valid !== 1'b0) begin
            n_err++; $display("FAIL parity_empty: parity %b valid %b want 0 0", o_parity, o_valid);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_bit = 1'b0; i_ready = 1'b0;
        part_val = 0; part_n = 0; wc_m = 8'd0;
        test_reset();
        test_order_latency();
        test_backpressure();
        test_simul_push_pop();
        test_midword_reset();
        test_random();
        test_wrap_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
